// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbiter and its requester agents.
// beat_t is the bus beat layout at the default data width, reused by the arbiter bus mux.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam int ARB_DEPTH  = 4;
  localparam int ARB_DATA_W = 32;
  localparam int PTR_W      = $clog2(ARB_DEPTH);

  typedef struct packed {
    logic                  last;
    logic [ARB_DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/arb_req_fifo.sv
// Synchronous FIFO with a combinational head. Push and pop may share a cycle, including when full.
// Latency: a pushed word is visible at dout the cycle after the push. Reset flushes by clearing the pointers.
module arb_req_fifo
  import arb_pkg::*;
#(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: stale words are never read once the pointers are cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/arb_requester.sv
// Requester agent: buffers packets, requests the arbiter, drains one packet per grant; req rises 2 cycles after the last push.
// bus_valid follows grant and FIFO occupancy; cmd_ready drops when the FIFO is full or during reset.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int WAIT_LIMIT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [DATA_W-1:0]        cmd_data,
  input  logic                     cmd_last,
  output logic                     req,
  input  logic                     grant,
  output logic                     bus_valid,
  input  logic                     bus_ready,
  output logic [DATA_W-1:0]        bus_data,
  output logic                     bus_last,
  output logic                     starve,
  output logic [$clog2(DEPTH):0]   pkt_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(WAIT_LIMIT + 1);

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic [CW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            starve_q, starve_d;
  logic [DATA_W:0] fifo_dout;
  logic            full, empty;
  logic            push, pop;
  logic            push_last, pop_last;

  assign cmd_ready = ~full & ~rst;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = bus_valid & bus_ready;
  assign push_last = push & cmd_last;
  assign pop_last  = pop & bus_last;
  assign bus_data  = fifo_dout[DATA_W-1:0];
  assign bus_last  = fifo_dout[DATA_W];
  assign req       = req_q;
  assign starve    = starve_q;
  assign pkt_cnt   = pkt_cnt_q;

  arb_req_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({cmd_last, cmd_data}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A full FIFO with no complete packet still requests, so long packets cut through.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((pkt_cnt_q != '0) || full) state_d = REQ;
      REQ:     if (grant) state_d = XFER;
      XFER:    if (pop_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d     = (state_d != IDLE);
    bus_valid = (state_q == XFER) & grant & ~empty & ~rst;
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (push_last && !pop_last) begin
      pkt_cnt_d = pkt_cnt_q + CW'(1);
    end else if (!push_last && pop_last) begin
      pkt_cnt_d = pkt_cnt_q - CW'(1);
    end

    wait_cnt_d = wait_cnt_q;
    if (state_q == REQ) begin
      if (grant) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q != WW'(WAIT_LIMIT)) begin
        wait_cnt_d = wait_cnt_q + WW'(1);
      end
    end

    // The counter only reaches the limit in REQ, where a last-beat pop cannot occur.
    starve_d = starve_q;
    if (pop_last) begin
      starve_d = 1'b0;
    end else if (wait_cnt_d == WW'(WAIT_LIMIT)) begin
      starve_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= 1'b0;
      pkt_cnt_q  <= '0;
      wait_cnt_q <= '0;
      starve_q   <= 1'b0;
    end else begin
      req_q      <= req_d;
      pkt_cnt_q  <= pkt_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= starve_d;
    end
  end

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Client-side agent for the round-robin arbiter; one instance per requester port.
- Buffers upstream packets in a small FIFO and raises `req` to the arbiter.
- While `grant` is high it drains one whole packet onto the shared bus with valid/ready, then releases `req`.
- A watchdog flags starvation when `grant` never arrives.

Parameters:
- DATA_W, 32, width of a data beat.
- DEPTH, 4, FIFO entries (beats); power of two, at least 2.
- WAIT_LIMIT, 255, cycles in REQ without `grant` before `starve` sets; must be at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  upstream beat valid.
- cmd_ready  out  1  upstream beat accepted when cmd_valid & cmd_ready.
- cmd_data  in  DATA_W  upstream beat payload.
- cmd_last  in  1  marks the final beat of a packet.
- req  out  1  request to the arbiter; registered.
- grant  in  1  this requester's grant bit from the arbiter.
- bus_valid  out  1  beat valid on the shared bus.
- bus_ready  in  1  bus accepts the beat when bus_valid & bus_ready.
- bus_data  out  DATA_W  FIFO head payload.
- bus_last  out  1  FIFO head last flag.
- starve  out  1  sticky starvation flag.
- pkt_cnt  out  $clog2(DEPTH)+1  complete packets held in the FIFO.

Behaviour:
- Reset:
  - rst is sampled on clk; while it is high the FIFO is flushed and pointers and counts go to 0.
  - State goes to IDLE; req=0, bus_valid=0, starve=0, pkt_cnt=0.
  - cmd_ready is forced to 0 while rst=1.
  - Reset mid-burst abandons the packet; buffered beats are lost.
- FIFO:
  - DEPTH x (DATA_W+1) storage.
  - cmd_ready = !full & !rst.
  - Push on cmd_valid & cmd_ready; pop on bus_valid & bus_ready.
  - Push and pop in the same cycle are both legal when full and when empty (empty: pop impossible, push proceeds).
  - Pointers wrap modulo DEPTH.
- pkt_cnt:
  - Increments on a push with cmd_last=1; decrements on a pop with bus_last=1.
  - Both in one cycle: unchanged.
- FSM states IDLE, REQ, XFER:
  - IDLE: req=0. If pkt_cnt!=0 or full, go to REQ next cycle. The full condition is the cut-through case for packets longer than DEPTH.
  - REQ: req=1. The wait counter increments each cycle with grant=0. If grant=1, go to XFER next cycle and clear the wait counter.
  - XFER: req=1. bus_valid = grant & !empty. bus_data/bus_last come from the FIFO head.
    - A pop with bus_last=1 returns to IDLE; req is 0 in the following cycle.
    - If grant drops mid-burst: bus_valid=0, stay in XFER, hold req=1, resume when grant returns. The wait counter is not advanced in XFER.
    - If empty mid-burst (cut-through): bus_valid=0 until the next beat arrives.
- Latency:
  - Last beat pushed at cycle t into an idle block: req=1 at t+2.
  - grant seen at t: first bus beat possible at t+1.
  - Back-to-back packets: at least one IDLE cycle with req=0, so the arbiter can rotate.
- Watchdog:
  - When the wait counter reaches WAIT_LIMIT in REQ, starve sets to 1.
  - starve clears only on the pop of a beat with bus_last=1, or on rst.
  - The counter saturates at WAIT_LIMIT.
- bus_data/bus_last are don't-care when bus_valid=0.
- bus_valid must not drop without a handshake unless grant drops.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, REQ, XFER};
  - localparam PTR_W = $clog2(DEPTH);
  - beat typedef {last, data}, reusable by the arbiter's bus mux.
- One natural sub-module: arb_req_fifo, a synchronous FIFO with full/empty outputs and simultaneous push/pop.
- FSM, pkt_cnt and watchdog stay in the top level.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with cmd_valid=1 -> req=0, bus_valid=0, starve=0, pkt_cnt=0, cmd_ready=0 throughout; cmd_ready=1 the cycle after rst drops.
2. Single packet, grant tied 1: push 3 beats 0xA1,0xA2,0xA3 (last on 0xA3) with bus_ready=1 -> req rises 2 cycles after the last push; bus carries A1,A2,A3 on consecutive cycles with bus_last only on A3; req=0 the cycle after; pkt_cnt back to 0.
3. Backpressure and grant drop: during a 4-beat packet, drop grant for 2 cycles after beat 2 and drop bus_ready for 1 cycle after beat 3 -> no beat lost or duplicated, order preserved, req stays 1 for the whole packet.
4. Full and cut-through: DEPTH=4, push a 6-beat packet with grant=0 -> cmd_ready=0 after 4 beats, req=1 while pkt_cnt=0; then grant=1 -> all 6 beats delivered in order.
5. Starvation: WAIT_LIMIT=5, packet queued, grant=0 for 10 cycles -> starve=1 after the 5th waiting cycle and stays 1; grant=1 -> starve clears on the pop of the last beat.
6. Simultaneous events: push a last beat while a last beat pops -> pkt_cnt unchanged. Assert rst during XFER -> next cycle IDLE, FIFO empty, req=0, bus_valid=0.
